// File: rtl/pe_inst_sequencer_pkg.sv
// Shared definitions for the PE instruction sequencer: state encoding,
// the NOP control word and the default widths shared with the PE.
package pe_inst_sequencer_pkg;

    localparam int DEF_INST_DWIDTH = 72;
    localparam int DEF_INST_AWIDTH = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } seq_state_t;

    // Wea=Web=0 and every other field zero: the PE treats this as a no-op.
    localparam logic [DEF_INST_DWIDTH-1:0] NOP_INST = '0;

    function automatic logic state_is_busy(input seq_state_t st);
        return (st == RUN) || (st == DRAIN);
    endfunction

endpackage

// File: rtl/pe_inst_ram.sv
// Simple dual-port instruction RAM: one synchronous write port and one
// registered read port; a same-cycle write to the read address is returned.
module pe_inst_ram #(
    parameter int INST_DWIDTH = 72,
    parameter int INST_AWIDTH = 10
) (
    input  logic                   Clk,
    input  logic                   wr_en,
    input  logic [INST_AWIDTH-1:0] wr_addr,
    input  logic [INST_DWIDTH-1:0] wr_data,
    input  logic                   rd_en,
    input  logic [INST_AWIDTH-1:0] rd_addr,
    output logic [INST_DWIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** INST_AWIDTH;

    logic [INST_DWIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/pe_inst_sequencer.sv
// Host-loadable instruction sequencer: replays words 0..N-1 for M iterations,
// holds busy through the PE pipeline drain, then pulses Done.
module pe_inst_sequencer
    import pe_inst_sequencer_pkg::*;
#(
    parameter int INST_DWIDTH  = DEF_INST_DWIDTH,
    parameter int INST_AWIDTH  = DEF_INST_AWIDTH,
    parameter int ITER_WIDTH   = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Host_Wr_En,
    input  logic [INST_AWIDTH-1:0] Host_Wr_Addr,
    input  logic [INST_DWIDTH-1:0] Host_Wr_Data,
    output logic                   Host_Wr_Err,
    input  logic                   Start,
    input  logic [INST_AWIDTH:0]   Inst_Count,
    input  logic [ITER_WIDTH-1:0]  Iter_Count,
    output logic [INST_DWIDTH-1:0] Inst_Out,
    output logic                   Inst_Valid,
    output logic                   PE_Array_Busy,
    output logic                   Done
);

    localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    seq_state_t             state_reg, state_next;
    logic [INST_AWIDTH-1:0] rd_addr_reg, rd_addr_next;
    logic [INST_AWIDTH-1:0] last_addr_reg, last_addr_next;
    logic [ITER_WIDTH-1:0]  iter_reg, iter_next;
    logic [DRAIN_W-1:0]     drain_reg, drain_next;
    logic                   valid_reg;
    logic                   wr_err_reg;

    logic                   ram_wr_en;
    logic                   ram_rd_en;
    logic [INST_DWIDTH-1:0] ram_rd_data;

    // Writes are only accepted while idle so a running program never changes.
    assign ram_wr_en = Host_Wr_En && (state_reg == IDLE);
    assign ram_rd_en = (state_reg == RUN);

    pe_inst_ram #(
        .INST_DWIDTH (INST_DWIDTH),
        .INST_AWIDTH (INST_AWIDTH)
    ) u_ram (
        .Clk     (Clk),
        .wr_en   (ram_wr_en),
        .wr_addr (Host_Wr_Addr),
        .wr_data (Host_Wr_Data),
        .rd_en   (ram_rd_en),
        .rd_addr (rd_addr_reg),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg     <= IDLE;
            rd_addr_reg   <= '0;
            last_addr_reg <= '0;
            iter_reg      <= '0;
            drain_reg     <= '0;
            valid_reg     <= 1'b0;
            wr_err_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rd_addr_reg   <= rd_addr_next;
            last_addr_reg <= last_addr_next;
            iter_reg      <= iter_next;
            drain_reg     <= drain_next;
            valid_reg     <= (state_reg == RUN);
            wr_err_reg    <= Host_Wr_En && (state_reg != IDLE);
        end
    end

    always_comb begin
        state_next     = state_reg;
        rd_addr_next   = rd_addr_reg;
        last_addr_next = last_addr_reg;
        iter_next      = iter_reg;
        drain_next     = drain_reg;

        case (state_reg)
            IDLE: begin
                if (Start) begin
                    if ((Inst_Count == '0) || (Iter_Count == '0)) begin
                        state_next = FIN;
                    end else begin
                        state_next     = RUN;
                        rd_addr_next   = '0;
                        // N-1 always fits the address width since 1 <= N <= depth.
                        last_addr_next = INST_AWIDTH'(Inst_Count - (INST_AWIDTH + 1)'(1));
                        iter_next      = Iter_Count;
                    end
                end
            end
            RUN: begin
                if (rd_addr_reg == last_addr_reg) begin
                    rd_addr_next = '0;
                    if (iter_reg != ITER_WIDTH'(1)) begin
                        iter_next = iter_reg - ITER_WIDTH'(1);
                    end else begin
                        iter_next  = '0;
                        drain_next = DRAIN_W'(DRAIN_CYCLES);
                        state_next = DRAIN;
                    end
                end else begin
                    rd_addr_next = rd_addr_reg + INST_AWIDTH'(1);
                end
            end
            DRAIN: begin
                if (drain_reg == '0) begin
                    state_next = FIN;
                end else begin
                    drain_next = drain_reg - DRAIN_W'(1);
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign Inst_Valid    = valid_reg;
    assign Inst_Out      = valid_reg ? ram_rd_data : INST_DWIDTH'(NOP_INST);
    assign PE_Array_Busy = state_is_busy(state_reg);
    assign Done          = (state_reg == FIN);
    assign Host_Wr_Err   = wr_err_reg;

endmodule
